action_dispatcher: RTL and testbench
====================================

// Module: action_dispatcher
// PURPOSE
//  Upstream stage of the primitive executor. Queues packet action requests from the match stage,
//  reads the action-table entry in SRAM to get the primitive-list address, then drives the executor
//  start/done handshake. Reports one completion (tag, error) per request.
// PARAMETERS
//  TABLE_BASE     32'h0000_1000  byte address of action table; entry i at TABLE_BASE + 4*i
//  NUM_ACTIONS    256            valid action ids are 0..NUM_ACTIONS-1
//  FIFO_DEPTH     4              request queue depth, power of 2, >= 2
//  MEM_RD_LAT     2              clock edges from registered address to mem_data_i capture
//  TIMEOUT_CYCLES 4096           maximum wait on exec_done_i in either polarity
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  req_valid_i    in   1   request valid
//  req_ready_o    out  1   queue not full
//  req_action_i   in   16  action id
//  req_tag_i      in   8   opaque packet tag, returned on completion
//  mem_ce_o       out  1   SRAM chip enable
//  mem_we_o       out  1   SRAM write enable; always 0 (read-only master)
//  mem_addr_o     out  32  SRAM byte address
//  mem_width_o    out  4   access width in bytes; 4 while reading, else 0
//  mem_data_i     in   32  SRAM read data
//  exec_start_o   out  1   executor start (level)
//  exec_addr_o    out  32  primitive-list start address; stable while exec_start_o=1
//  exec_done_i    in   1   executor done (level)
//  cpl_valid_o    out  1   completion pulse, 1 cycle
//  cpl_tag_o      out  8   tag of completed request
//  cpl_err_o      out  2   0 ok, 1 bad action id, 2 timeout
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready_o=1; FIFO empty; state IDLE; counters 0. rst mid-operation
//   drops exec_start_o on the next edge and discards queued requests. No completion is emitted.
//  Enqueue on req_valid_i & req_ready_o. Simultaneous push and pop while full is not allowed,
//   because req_ready_o=0 when full. Pop occurs in IDLE.
//  FSM: IDLE -> pop head when FIFO non-empty.
//   Action id >= NUM_ACTIONS: go to REPORT with err=1. No SRAM access.
//   Otherwise register mem_addr_o = TABLE_BASE + {action,2'b00}, mem_ce_o=1, width=4, go RD_WAIT.
//  RD_WAIT: count MEM_RD_LAT edges, then capture entry = mem_data_i. Set mem_ce_o=0, width=0.
//   entry==0: no primitives; go REPORT with err=0 and skip the executor.
//   Otherwise exec_addr_o = {entry[31:2],2'b00}; go START.
//  START: precondition exec_done_i=0. If done is still high, wait here; this wait shares the timeout.
//   Assert exec_start_o=1; go RUN; clear the timeout counter.
//  RUN: hold exec_start_o=1 until exec_done_i=1.
//   Then exec_start_o=0 on the next edge; go RELEASE.
//  RELEASE: wait exec_done_i=0; go REPORT.
//  REPORT: cpl_valid_o=1 for exactly 1 cycle with the tag and err; go IDLE.
//   Minimum 1 idle cycle between requests.
//  Timeout: a 16-bit counter increments in START, RUN and RELEASE. When it reaches TIMEOUT_CYCLES-1:
//   exec_start_o=0; go REPORT with err=2. Do not wait for done to drop.
//  Latency, ok path with empty FIFO: push at edge 0, pop at edge 1, address at edge 1,
//   entry at edge 1+MEM_RD_LAT, exec_start_o at the next edge.
//  exec_addr_o and cpl_tag_o are held until overwritten by the next request.
// STRUCTURE
//  Shared package/def include: state encodings (DSP_IDLE..DSP_REPORT, 3 bits),
//   error codes CPL_OK/CPL_BAD_ID/CPL_TIMEOUT, existing ADDR_BUS/DATA_BUS/TRUE/FALSE.
//  One sub-module, sync_fifo (WIDTH=24, DEPTH=FIFO_DEPTH): registered full/empty and wrap-around
//   pointers with an extra MSB. Everything else stays in one FSM process.
// TESTING
//  1. Entry[5]=32'h0000_2003; push action 5, tag 8'hA1; model done 10 cycles after start.
//     Expect mem_addr_o=32'h1014 and exec_addr_o=32'h2000; cpl tag A1, err 0.
//  2. Entry[7]=0; push action 7, tag 8'h07. Expect no exec_start_o; cpl err 0 within 2+MEM_RD_LAT
//     cycles of the pop.
//  3. Push action 16'd300, tag 8'h33. Expect mem_ce_o to stay 0; cpl err 1.
//  4. Hold exec_done_i=0 forever. Expect exec_start_o to drop after 4096 cycles in RUN; cpl err 2;
//     the next queued request proceeds.
//  5. Push 5 back-to-back requests with DEPTH 4. Expect req_ready_o=0 after the 4th until the first
//     pop. Completions arrive in push order with tags intact.
//  6. Assert rst while in RUN. Expect exec_start_o=0 and req_ready_o=1 next cycle, no cpl_valid_o;
//     after reset a fresh request completes normally.

Source files
------------

// File: rtl/action_dispatcher_pkg.sv
// action_dispatcher_pkg: shared encodings, bus widths and request layout for the action dispatcher.
package action_dispatcher_pkg;
  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic [2:0] {
    DSP_IDLE, DSP_RD_WAIT, DSP_START, DSP_RUN, DSP_RELEASE, DSP_REPORT
  } dsp_state_e;
  typedef enum logic [1:0] {
    CPL_OK = 2'd0, CPL_BAD_ID = 2'd1, CPL_TIMEOUT = 2'd2
  } cpl_err_e;
  typedef struct packed {
    logic [15:0] action;
    logic [7:0]  tag;
  } req_t;
  function automatic logic [ADDR_BUS-1:0] entry_addr(input logic [ADDR_BUS-1:0] base, input logic [15:0] id);
    return base + {14'd0, id, 2'b00};
  endfunction
endpackage

// File: rtl/action_dispatcher_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty and extra-MSB wrap pointers.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic full_q, empty_q;
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push_i & ~full_q};
    rd_d = rd_q + {{AW{1'b0}}, pop_i & ~empty_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      full_q <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      empty_q <= wr_d == rd_d;
    end
  end
  always_ff @(posedge clk)
    if (push_i && !full_q) mem_q[wr_q[AW-1:0]] <= wdata_i;
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign full_o = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/action_dispatcher.sv
// action_dispatcher: queues action requests, fetches the primitive-list address and runs the executor handshake.
module action_dispatcher
  import action_dispatcher_pkg::*;
#(
  parameter logic [31:0] TABLE_BASE = 32'h0000_1000,
  parameter int NUM_ACTIONS = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_RD_LAT = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [15:0]         req_action_i,
  input  logic [7:0]          req_tag_i,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_BUS-1:0] mem_addr_o,
  output logic [3:0]          mem_width_o,
  input  logic [DATA_BUS-1:0] mem_data_i,
  output logic                exec_start_o,
  output logic [ADDR_BUS-1:0] exec_addr_o,
  input  logic                exec_done_i,
  output logic                cpl_valid_o,
  output logic [7:0]          cpl_tag_o,
  output logic [1:0]          cpl_err_o
);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] RD_LAST = 8'(MEM_RD_LAT - 1);
  req_t head;
  logic fifo_full, fifo_empty, pop;
  dsp_state_e state_q;
  logic [15:0] to_q;
  logic [7:0] rd_cnt_q;
  logic ce_q, start_q, cpl_valid_q;
  logic [ADDR_BUS-1:0] addr_q, exec_addr_q;
  logic [7:0] tag_q;
  cpl_err_e err_q;
  assign pop = (state_q == DSP_IDLE) && !fifo_empty;
  sync_fifo #(.WIDTH(24), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(req_valid_i & ~fifo_full),
    .pop_i(pop),
    .wdata_i({req_action_i, req_tag_i}),
    .rdata_o(head),
    .full_o(fifo_full),
    .empty_o(fifo_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DSP_IDLE;
      to_q <= '0;
      rd_cnt_q <= '0;
      ce_q <= FALSE;
      start_q <= FALSE;
      cpl_valid_q <= FALSE;
      addr_q <= '0;
      exec_addr_q <= '0;
      tag_q <= '0;
      err_q <= CPL_OK;
    end else begin
      cpl_valid_q <= FALSE;
      case (state_q)
        DSP_IDLE: if (pop) begin
          tag_q <= head.tag;
          if (head.action >= 16'(NUM_ACTIONS)) begin
            err_q <= CPL_BAD_ID;
            cpl_valid_q <= TRUE;
            state_q <= DSP_REPORT;
          end else begin
            addr_q <= entry_addr(TABLE_BASE, head.action);
            ce_q <= TRUE;
            rd_cnt_q <= '0;
            state_q <= DSP_RD_WAIT;
          end
        end
        DSP_RD_WAIT: if (rd_cnt_q == RD_LAST) begin
          ce_q <= FALSE;
          to_q <= '0;
          if (mem_data_i == '0) begin
            err_q <= CPL_OK;
            cpl_valid_q <= TRUE;
            state_q <= DSP_REPORT;
          end else begin
            exec_addr_q <= {mem_data_i[31:2], 2'b00};
            state_q <= DSP_START;
          end
        end else rd_cnt_q <= rd_cnt_q + 8'd1;
        DSP_START, DSP_RUN, DSP_RELEASE: if (to_q == TO_MAX) begin
          // timeout abandons the executor without waiting for done to drop
          start_q <= FALSE;
          err_q <= CPL_TIMEOUT;
          cpl_valid_q <= TRUE;
          state_q <= DSP_REPORT;
        end else begin
          to_q <= to_q + 16'd1;
          if (state_q == DSP_START && !exec_done_i) begin
            start_q <= TRUE;
            to_q <= '0;
            state_q <= DSP_RUN;
          end else if (state_q == DSP_RUN && exec_done_i) begin
            start_q <= FALSE;
            state_q <= DSP_RELEASE;
          end else if (state_q == DSP_RELEASE && !exec_done_i) begin
            err_q <= CPL_OK;
            cpl_valid_q <= TRUE;
            state_q <= DSP_REPORT;
          end
        end
        default: state_q <= DSP_IDLE;
      endcase
    end
  end
  assign req_ready_o = ~fifo_full;
  assign mem_ce_o = ce_q;
  assign mem_we_o = FALSE;
  assign mem_addr_o = addr_q;
  assign mem_width_o = ce_q ? 4'd4 : 4'd0;
  assign exec_start_o = start_q;
  assign exec_addr_o = exec_addr_q;
  assign cpl_valid_o = cpl_valid_q;
  assign cpl_tag_o = tag_q;
  assign cpl_err_o = err_q;
endmodule

// File: tb/tb_action_dispatcher.sv
// tb_action_dispatcher: directed bench with SRAM and executor models around action_dispatcher.
module tb_action_dispatcher;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [15:0] req_action_i = '0;
  logic [7:0] req_tag_i = '0;
  logic mem_ce_o, mem_we_o, exec_start_o, cpl_valid_o;
  logic [31:0] mem_addr_o, exec_addr_o;
  logic [31:0] mem_data = '0;
  logic [3:0] mem_width_o;
  logic done = 1'b0;
  logic [7:0] cpl_tag_o;
  logic [1:0] cpl_err_o;
  int n_vec = 0, n_bad = 0;
  bit hang = 0;
  int ex_cnt = 0, ce_cnt = 0, start_cnt = 0, cpl_cnt = 0;
  logic prev_start = 1'b0;
  always #5 clk = ~clk;
  action_dispatcher dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_action_i(req_action_i), .req_tag_i(req_tag_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_i(mem_data),
    .exec_start_o(exec_start_o), .exec_addr_o(exec_addr_o), .exec_done_i(done),
    .cpl_valid_o(cpl_valid_o), .cpl_tag_o(cpl_tag_o), .cpl_err_o(cpl_err_o)
  );
  // action table: entry 5 -> 0x2003, entry 7 -> 0, everything else non-zero
  always @(posedge clk)
    if (mem_ce_o)
      mem_data <= (mem_addr_o == 32'h1014) ? 32'h0000_2003 :
                  (mem_addr_o == 32'h101C) ? 32'h0 : 32'hDEAD_BEE0;
  always @(posedge clk)
    if (rst || !exec_start_o) begin
      ex_cnt <= 0;
      done <= 1'b0;
    end else if (!hang) begin
      if (ex_cnt == 9) done <= 1'b1;
      else ex_cnt <= ex_cnt + 1;
    end
  always @(negedge clk) begin
    ce_cnt <= ce_cnt + int'(mem_ce_o);
    start_cnt <= start_cnt + int'(exec_start_o && !prev_start);
    cpl_cnt <= cpl_cnt + int'(cpl_valid_o);
    prev_start <= exec_start_o;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask
  task automatic push(input logic [15:0] act, input logic [7:0] tag);
    int k = 0;
    req_valid_i = 1'b1;
    req_action_i = act;
    req_tag_i = tag;
    while (!req_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("push_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask
  task automatic wait_cpl(input string name, input int n, input logic [7:0] tag, input logic [1:0] err);
    bit got = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpl_valid_o) begin
        got = 1;
        break;
      end
    end
    check({name, "_seen"}, 32'(got), 32'd1);
    check({name, "_tag"}, 32'(cpl_tag_o), 32'(tag));
    check({name, "_err"}, 32'(cpl_err_o), 32'(err));
  endtask
  task automatic wait_start(input string name, input int n);
    bit got = 0;
    for (int i = 0; i < n && !got; i++) begin
      if (exec_start_o) got = 1;
      else @(negedge clk);
    end
    check(name, 32'(exec_start_o), 32'd1);
  endtask
  initial begin
    int snap, snap2, run;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_ce", 32'(mem_ce_o), 32'd0);
    check("rst_start", 32'(exec_start_o), 32'd0);
    check("rst_cpl", 32'(cpl_valid_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_exec_addr", exec_addr_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // 1: normal path with exact latency
    push(16'd5, 8'hA1);
    @(negedge clk);
    check("t1_ce", 32'(mem_ce_o), 32'd1);
    check("t1_addr", mem_addr_o, 32'h1014);
    check("t1_width", 32'(mem_width_o), 32'd4);
    check("t1_we", 32'(mem_we_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("t1_ce_off", 32'(mem_ce_o), 32'd0);
    check("t1_width_off", 32'(mem_width_o), 32'd0);
    @(negedge clk);
    check("t1_start", 32'(exec_start_o), 32'd1);
    check("t1_exec_addr", exec_addr_o, 32'h2000);
    wait_cpl("t1", 40, 8'hA1, 2'd0);
    // 2: empty entry skips the executor
    snap = start_cnt;
    push(16'd7, 8'h07);
    wait_cpl("t2", 5, 8'h07, 2'd0);
    check("t2_no_start", 32'(start_cnt - snap), 32'd0);
    // 3: bad id never touches SRAM
    @(negedge clk);
    snap = ce_cnt;
    push(16'd300, 8'h33);
    wait_cpl("t3", 4, 8'h33, 2'd1);
    check("t3_no_ce", 32'(ce_cnt - snap), 32'd0);
    // 4: executor never finishes; next queued request still runs
    hang = 1;
    push(16'd9, 8'h44);
    push(16'd5, 8'h55);
    wait_start("t4_start", 10);
    check("t4_exec_addr", exec_addr_o, 32'hDEAD_BEE0);
    run = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!exec_start_o) break;
      run++;
    end
    check("t4_run_cycles", 32'(run), 32'd4096);
    check("t4_cpl", 32'(cpl_valid_o), 32'd1);
    check("t4_tag", 32'(cpl_tag_o), 32'h44);
    check("t4_err", 32'(cpl_err_o), 32'd2);
    hang = 0;
    wait_cpl("t4_next", 60, 8'h55, 2'd0);
    // 5: fill the queue behind a running request
    @(negedge clk);
    push(16'd5, 8'hB0);
    wait_start("t5_start", 10);
    push(16'd5, 8'hB1);
    push(16'd7, 8'hB2);
    push(16'd300, 8'hB3);
    push(16'd5, 8'hB4);
    check("t5_full", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    check("t5_full_hold", 32'(req_ready_o), 32'd0);
    wait_cpl("t5_b0", 60, 8'hB0, 2'd0);
    wait_cpl("t5_b1", 60, 8'hB1, 2'd0);
    wait_cpl("t5_b2", 60, 8'hB2, 2'd0);
    wait_cpl("t5_b3", 60, 8'hB3, 2'd1);
    wait_cpl("t5_b4", 60, 8'hB4, 2'd0);
    // 6: reset in RUN discards state and the queued request
    @(negedge clk);
    push(16'd5, 8'h66);
    wait_start("t6_start", 10);
    push(16'd9, 8'h77);
    check("t6_still_run", 32'(exec_start_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_start_drop", 32'(exec_start_o), 32'd0);
    check("t6_ready", 32'(req_ready_o), 32'd1);
    check("t6_no_cpl", 32'(cpl_valid_o), 32'd0);
    rst = 1'b0;
    snap = cpl_cnt;
    snap2 = ce_cnt;
    repeat (6) @(negedge clk);
    check("t6_quiet_cpl", 32'(cpl_cnt - snap), 32'd0);
    check("t6_quiet_ce", 32'(ce_cnt - snap2), 32'd0);
    push(16'd5, 8'h88);
    wait_cpl("t6_fresh", 40, 8'h88, 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
